// File: rtl/riscv_opcodes_pkg.sv
// riscv_opcodes_pkg: RV opcode (instr[6:2]) and load funct3 constants
// plus small decode helpers shared by the write-back stage.
package riscv_opcodes_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic logic writes_rd(logic [4:0] opc, int xlen);
        unique case (opc)
            OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM:
                return 1'b1;
            OPC_OP32, OPC_OP_IMM32:
                return xlen == 64;
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(logic [2:0] f3, logic [2:0] off);
        unique case (f3)
            F3_LH, F3_LHU: return off[0];
            F3_LW, F3_LWU: return |off[1:0];
            F3_LD:         return |off;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_state_pkg.sv
// riscv_state_pkg: write-back stage FSM state encoding.
package riscv_state_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } wb_state_t;

endpackage

// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: pipeline bundle types passed between MEM and WB.
package riscv_wb_pkg;

    localparam int ILEN = 32;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic            bubble;
        logic            retired;
        logic            dbg;
    } instruction_t;

    typedef struct packed {
        logic misaligned_instruction;
        logic instruction_access_fault;
        logic illegal_instruction;
        logic breakpoint;
        logic misaligned_load;
        logic load_access_fault;
        logic misaligned_store;
        logic store_access_fault;
        logic ecall;
    } exceptions_t;

    typedef struct packed {
        logic [2:0]  interrupts;
        exceptions_t exceptions;
        logic        any;
    } interrupts_exceptions_t;

    localparam instruction_t INSN_NOP = '{
        instr:   32'h0000_0013,
        bubble:  1'b1,
        retired: 1'b0,
        dbg:     1'b0
    };

endpackage

// File: rtl/riscv_wb_if.sv
// riscv_wb_if: data-memory read response bus into the write-back stage.
interface riscv_wb_if #(
    parameter int XLEN = 32
);
    logic            ack;
    logic            err;
    logic [XLEN-1:0] q;

    modport master (output ack, err, q);
    modport slave  (input  ack, err, q);
endinterface

// File: rtl/riscv_ld_align.sv
// riscv_ld_align: lane shift and sign/zero extension of load data.
module riscv_ld_align
    import riscv_opcodes_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             q,
    input  logic [$clog2(XLEN/8)-1:0]   offset,
    input  logic [2:0]                  funct3,
    output logic [XLEN-1:0]             data
);

    logic [XLEN-1:0] sh;

    // Lanes above the addressed byte shift in as zero.
    assign sh = q >> {offset, 3'b000};

    always_comb begin
        data = '0;
        unique case (funct3)
            F3_LB:   data = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_LH:   data = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_LW:   data = XLEN'($signed(sh[31:0]));
            F3_LBU:  data = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, sh[15:0]};
            F3_LD:   if (XLEN == 64) data = sh;
            F3_LWU:  if (XLEN == 64) data = XLEN'(sh[31:0]);
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/riscv_wb.sv
// riscv_wb: RV12 write-back stage (load wait, align, precise bus faults).
// Define RISCV_WB_MISALIGNED_CHECK_EN to trap misaligned loads here.
module riscv_wb
    import riscv_wb_pkg::*;
    import riscv_opcodes_pkg::*;
    import riscv_state_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   wb_stall_o,
    input  logic [XLEN-1:0]        wb_pc_i,
    input  instruction_t           wb_insn_i,
    input  interrupts_exceptions_t wb_exceptions_i,
    input  logic [XLEN-1:0]        wb_r_i,
    input  logic [XLEN-1:0]        wb_memadr_i,
    riscv_wb_if.slave              dmem,
    output logic [XLEN-1:0]        wb_pc_o,
    output instruction_t           wb_insn_o,
    output interrupts_exceptions_t wb_exceptions_o,
    output logic                   wb_we_o,
    output logic [4:0]             wb_dst_o,
    output logic [XLEN-1:0]        wb_r_o
);

    localparam int OW = $clog2(XLEN / 8);

    wb_state_t              state;
    wb_state_t              nxt;
    logic [4:0]             opc;
    logic [2:0]             f3;
    logic [4:0]             rd;
    logic [OW-1:0]          offset;
    logic                   resp;
    logic                   is_ld;
    logic                   mis;
    logic                   wait_ld;
    logic                   err_hit;
    logic                   capture;
    logic                   we_n;
    logic [XLEN-1:0]        ld_data;
    instruction_t           insn_n;
    interrupts_exceptions_t exc_n;
    logic                   unused_adr;

    assign opc        = wb_insn_i.instr[6:2];
    assign f3         = wb_insn_i.instr[14:12];
    assign rd         = wb_insn_i.instr[11:7];
    assign offset     = wb_memadr_i[OW-1:0];
    assign unused_adr = ^wb_memadr_i[XLEN-1:OW];

    assign resp  = dmem.ack | dmem.err;
    assign is_ld = !wb_insn_i.bubble
                && (opc == OPC_LOAD)
                && !wb_exceptions_i.any;

`ifdef RISCV_WB_MISALIGNED_CHECK_EN
    assign mis = is_ld & misaligned(f3, 3'(offset));
`else
    assign mis = 1'b0;
`endif

    assign wait_ld    = is_ld & !mis;
    assign err_hit    = wait_ld & dmem.err;
    assign wb_stall_o = wait_ld & !resp & !rst_i;

    riscv_ld_align #(
        .XLEN(XLEN)
    ) u_ld_align (
        .q      (dmem.q),
        .offset (offset),
        .funct3 (f3),
        .data   (ld_data)
    );

    always_comb begin
        nxt     = state;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (!wait_ld || resp) capture = 1'b1;
                else                  nxt     = WAIT;
            end
            WAIT: begin
                if (resp) begin
                    capture = 1'b1;
                    nxt     = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        insn_n = wb_insn_i;
        exc_n  = wb_exceptions_i;
        we_n   = !wb_insn_i.bubble
               & !wb_exceptions_i.any
               & (rd != 5'd0)
               & writes_rd(opc, XLEN);
        if (err_hit) begin
            exc_n.exceptions.load_access_fault = 1'b1;
            exc_n.any      = 1'b1;
            insn_n.retired = 1'b0;
            insn_n.bubble  = 1'b1;
            we_n           = 1'b0;
        end
        if (mis) begin
            exc_n.exceptions.misaligned_load = 1'b1;
            exc_n.any      = 1'b1;
            insn_n.retired = 1'b0;
            we_n           = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            wb_pc_o         <= PC_INIT;
            wb_insn_o       <= INSN_NOP;
            wb_exceptions_o <= '0;
            wb_we_o         <= 1'b0;
            wb_dst_o        <= 5'd0;
            wb_r_o          <= '0;
        end else begin
            state <= nxt;
            if (capture) begin
                wb_pc_o         <= wb_pc_i;
                wb_insn_o       <= insn_n;
                wb_exceptions_o <= exc_n;
                wb_we_o         <= we_n;
                wb_dst_o        <= rd;
                wb_r_o          <= wait_ld ? ld_data : wb_r_i;
            end else begin
                // Waiting cycles emit a bubble so nothing writes or retires twice.
                wb_insn_o.bubble  <= 1'b1;
                wb_insn_o.retired <= 1'b0;
                wb_exceptions_o   <= '0;
                wb_we_o           <= 1'b0;
            end
        end
    end

endmodule
